// File: rtl/mem_port_arbiter_if.sv
// Requestor + external memory bundle for mem_port_arbiter; slave is the arbiter's view,
// master is the requestor/memory side.
interface mem_port_arbiter_if #(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 26
);
  logic [NUM_CH-1:0]            REQ;
  logic [NUM_CH-1:0]            REQ_WE;
  logic [NUM_CH*ADDR_WIDTH-1:0] REQ_ADDR;
  logic [NUM_CH*DATA_WIDTH-1:0] REQ_WDATA;
  logic [NUM_CH-1:0]            ACK;
  logic [DATA_WIDTH-1:0]        RDATA;
  logic [ADDR_WIDTH-1:0]        MEM_ADDR;
  logic [DATA_WIDTH-1:0]        MEM_DATA_OUT;
  logic [DATA_WIDTH-1:0]        MEM_DATA_IN;
  logic                         MEM_READ;
  logic                         MEM_WRITE;

  modport slave (
    input  REQ, REQ_WE, REQ_ADDR, REQ_WDATA, MEM_DATA_IN,
    output ACK, RDATA, MEM_ADDR, MEM_DATA_OUT, MEM_READ, MEM_WRITE
  );

  modport master (
    output REQ, REQ_WE, REQ_ADDR, REQ_WDATA, MEM_DATA_IN,
    input  ACK, RDATA, MEM_ADDR, MEM_DATA_OUT, MEM_READ, MEM_WRITE
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_CH requestors; strobe held MEM_LAT
// cycles, one-cycle ACK after. Requestors wait with REQ held; one transaction in flight.
module mem_port_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 26,
  parameter int MEM_LAT    = 1
) (
  input logic               CLK,
  input logic               RST,
  mem_port_arbiter_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [CH_W-1:0]       last_q, last_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [CH_W:0]         pick;
  logic                  gnt_vld;
  logic [CH_W-1:0]       gnt_idx;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [NUM_CH-1:0]     ack;

  // Scan starts one past the last winner and wraps, so the last winner is checked last.
  function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                            input logic [CH_W-1:0]   last);
    logic [CH_W-1:0] c;
    logic [CH_W-1:0] idx;
    logic            found;
    c     = last;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = (c == CH_W'(NUM_CH - 1)) ? '0 : c + CH_W'(1);
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = c;
      end
    end
    return {found, idx};
  endfunction

  assign pick    = rr_pick(bus.REQ, last_q);
  assign gnt_vld = pick[CH_W];
  assign gnt_idx = pick[CH_W-1:0];

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_idx == CH_W'(i)) begin
        sel_we    = bus.REQ_WE[i];
        sel_addr  = bus.REQ_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = bus.REQ_WDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          ch_d    = gnt_idx;
          last_d  = gnt_idx;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          cnt_d   = CNT_W'(MEM_LAT - 1);
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            rdata_d = bus.MEM_DATA_IN;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      last_q  <= CH_W'(NUM_CH - 1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes decode straight from the async-reset state so they drop the moment RST rises.
  always_comb begin
    ack = '0;
    if (state_q == S_DONE) begin
      ack[ch_q] = 1'b1;
    end
  end

  assign bus.ACK          = ack;
  assign bus.RDATA        = rdata_q;
  assign bus.MEM_ADDR     = addr_q;
  assign bus.MEM_DATA_OUT = wdata_q;
  assign bus.MEM_READ     = (state_q == S_ACCESS) && !we_q;
  assign bus.MEM_WRITE    = (state_q == S_ACCESS) && we_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: rounds of requests predicted by a round-robin model,
// checked by an independent negedge monitor.
module tb_mem_port_arbiter;
  localparam int N   = 3;
  localparam int DW  = 32;
  localparam int AW  = 26;
  localparam int LAT = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  mem_port_arbiter_if #(.NUM_CH(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_port_arbiter #(.NUM_CH(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LAT(LAT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (a == 26'h10) return 32'hDEADBEEF;
    return {a[15:0], a[25:10]} ^ 32'hA5C3_0F69;
  endfunction

  assign bus.MEM_DATA_IN = mem_rd(bus.MEM_ADDR);

  typedef struct {
    int            ch;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    bit            b2b;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  int   strobe_cnt = 0;
  int   first_strobe = 0;
  int   last_ack = -100;
  bit   expect_abort = 1'b0;
  exp_t m;

  always @(negedge CLK) begin
    if (RST) begin
      strobe_cnt = 0;
    end else begin
      if (bus.MEM_READ || bus.MEM_WRITE) begin
        chk("strobe_excl", 64'(bus.MEM_READ & bus.MEM_WRITE), 64'd0);
        if (sb.size() == 0) begin
          if (!expect_abort) chk("unexpected_strobe", 64'd1, 64'd0);
        end else begin
          m = sb[0];
          chk("strobe_write", 64'(bus.MEM_WRITE), 64'(m.we));
          chk("strobe_read", 64'(bus.MEM_READ), 64'(!m.we));
          chk("mem_addr", 64'(bus.MEM_ADDR), 64'(m.addr));
          if (m.we) chk("mem_wdata", 64'(bus.MEM_DATA_OUT), 64'(m.wdata));
          if (strobe_cnt == 0) first_strobe = cyc;
          strobe_cnt++;
        end
      end
      if (bus.ACK != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 64'(bus.ACK), 64'd0);
        end else begin
          m = sb.pop_front();
          chk("ack_onehot", 64'(bus.ACK), 64'(N'(1) << m.ch));
          chk("rdata", 64'(bus.RDATA), 64'(m.rdata));
          chk("strobe_cycles", 64'(strobe_cnt), 64'(LAT));
          chk("ack_latency", 64'(cyc - first_strobe), 64'(LAT));
          chk("addr_hold", 64'(bus.MEM_ADDR), 64'(m.addr));
          if (m.b2b) chk("ack_spacing", 64'(cyc - last_ack), 64'(LAT + 2));
          last_ack   = cyc;
          strobe_cnt = 0;
        end
      end
    end
  end

  // Driver and reference model
  logic [N-1:0]  we_a;
  logic [AW-1:0] addr_a[N];
  logic [DW-1:0] wd_a[N];
  int            last_g = N - 1;
  logic [DW-1:0] last_rd = '0;

  task automatic apply_inputs(input logic [N-1:0] mask);
    bus.REQ_WE = we_a;
    for (int i = 0; i < N; i++) begin
      bus.REQ_ADDR[i*AW +: AW]  = addr_a[i];
      bus.REQ_WDATA[i*DW +: DW] = wd_a[i];
    end
    bus.REQ = mask;
  endtask

  // hold=0: each masked channel served once; hold>0: REQ stays up for hold transactions.
  task automatic run_round(input logic [N-1:0] mask, input int hold, input bit early);
    int   nexp, n, budget, c;
    exp_t x;
    nexp = (hold > 0) ? hold : $countones(mask);
    c = last_g;
    for (int k = 0; k < nexp; k++) begin
      c = (c + 1) % N;
      while (!mask[c]) c = (c + 1) % N;
      x.ch    = c;
      x.we    = we_a[c];
      x.addr  = addr_a[c];
      x.wdata = wd_a[c];
      if (!x.we) last_rd = mem_rd(x.addr);
      x.rdata = last_rd;
      x.b2b   = (k > 0);
      sb.push_back(x);
    end
    last_g = c;
    apply_inputs(mask);
    n = 0;
    budget = nexp * (LAT + 2) + 10;
    while (n < nexp && budget > 0) begin
      @(negedge CLK);
      budget--;
      if (early && (bus.MEM_READ || bus.MEM_WRITE)) bus.REQ = '0;
      if (bus.ACK != '0) begin
        n++;
        if (hold > 0) begin
          if (n == hold) bus.REQ = '0;
        end else begin
          bus.REQ = bus.REQ & ~bus.ACK;
        end
      end
    end
    if (n < nexp) begin
      chk("round_timeout", 64'(n), 64'(nexp));
      bus.REQ = '0;
      sb.delete();
    end
  endtask

  initial begin
    int wait_budget;
    bus.REQ = '0;
    bus.REQ_WE = '0;
    bus.REQ_ADDR = '0;
    bus.REQ_WDATA = '0;
    for (int i = 0; i < N; i++) begin
      we_a[i] = 1'b0; addr_a[i] = '0; wd_a[i] = '0;
    end

    // Reset with random requests: everything stays at 0.
    repeat (3) begin
      @(negedge CLK);
      bus.REQ = N'($urandom);
      bus.REQ_WE = N'($urandom);
      #1;
      chk("rst_ack", 64'(bus.ACK), 64'd0);
      chk("rst_rdata", 64'(bus.RDATA), 64'd0);
      chk("rst_addr", 64'(bus.MEM_ADDR), 64'd0);
      chk("rst_dout", 64'(bus.MEM_DATA_OUT), 64'd0);
      chk("rst_read", 64'(bus.MEM_READ), 64'd0);
      chk("rst_write", 64'(bus.MEM_WRITE), 64'd0);
    end
    bus.REQ = '0;
    @(negedge CLK);
    RST = 1'b0;

    // Fairness: all channels held high for 4 transactions -> 0,1,2,0.
    for (int i = 0; i < N; i++) begin
      we_a[i] = 1'b0; addr_a[i] = AW'(26'h100 + i); wd_a[i] = '0;
    end
    run_round('1, 4, 1'b0);

    // Directed read and write.
    we_a[0] = 1'b0; addr_a[0] = 26'h0000010;
    run_round(3'b001, 0, 1'b0);
    chk("read_rdata", 64'(bus.RDATA), 64'hDEADBEEF);
    we_a[1] = 1'b1; addr_a[1] = 26'h3FFFFFF; wd_a[1] = 32'h12345678;
    run_round(3'b010, 0, 1'b0);
    chk("write_keeps_rdata", 64'(bus.RDATA), 64'hDEADBEEF);

    // REQ dropped in the first access cycle: ACK still arrives.
    we_a[0] = 1'b0; addr_a[0] = 26'h0000020;
    run_round(3'b001, 0, 1'b1);

    // Async reset in the second strobe cycle.
    we_a[2] = 1'b0; addr_a[2] = 26'h0000030;
    expect_abort = 1'b1;
    apply_inputs(3'b100);
    wait_budget = 10;
    while (!bus.MEM_READ && wait_budget > 0) begin
      @(negedge CLK);
      wait_budget--;
    end
    chk("abort_strobe_seen", 64'(bus.MEM_READ), 64'd1);
    @(negedge CLK);
    chk("abort_strobe_c2", 64'(bus.MEM_READ), 64'd1);
    #1 RST = 1'b1;
    #1;
    chk("abort_read_drop", 64'(bus.MEM_READ), 64'd0);
    chk("abort_write_drop", 64'(bus.MEM_WRITE), 64'd0);
    bus.REQ = '0;
    @(negedge CLK);
    chk("abort_ack", 64'(bus.ACK), 64'd0);
    chk("abort_rdata", 64'(bus.RDATA), 64'd0);
    RST = 1'b0;
    expect_abort = 1'b0;
    last_g = N - 1;
    last_rd = '0;
    repeat (LAT + 3) begin
      @(negedge CLK);
      chk("abort_no_ack", 64'(bus.ACK), 64'd0);
    end
    for (int i = 0; i < N; i++) begin
      we_a[i] = 1'b0; addr_a[i] = AW'(26'h200 + i);
    end
    run_round('1, 1, 1'b0);

    // Random rounds.
    repeat (60) begin
      logic [N-1:0] mask;
      int hold;
      for (int i = 0; i < N; i++) begin
        we_a[i] = 1'($urandom);
        case ($urandom_range(0, 7))
          0: addr_a[i] = '0;
          1: addr_a[i] = 26'h3FFFFFF;
          2: addr_a[i] = 26'h0000010;
          default: addr_a[i] = AW'($urandom);
        endcase
        wd_a[i] = $urandom;
      end
      mask = N'($urandom_range(1, (1 << N) - 1));
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      run_round(mask, hold, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    repeat (5) @(negedge CLK);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
